mhpm_csr: RTL and testbench
===========================

Name: mhpm_csr

Overview:
- Parametrised machine-mode counter CSR bank; the next generation of the core's mcsr cycle-counter logic.
- Implements mcycle/h, minstret/h, NUM_HPM programmable mhpmcounter3+/h with mhpmevent3+ selectors, mcountinhibit, and the user read-only shadows (cycle/instret/hpmcounter).
- Sits beside mcsr on the same CSR read/write bus. The core ORs readdata according to o_csr_hit.

Parameters:
- NUM_HPM, 4, number of programmable counters (0..29), mapped to indices 3..3+NUM_HPM-1.
- CNT_WIDTH, 64, implemented counter width (32..64); bits above it read 0.
- NUM_EVENTS, 8, width of the i_events vector (1..31).

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- csr_read  input  1  CSR read strobe
- csr_write  input  1  CSR write strobe
- csr_address  input  12  CSR address
- csr_writedata  input  32  write data
- csr_readdata  output  32  combinational read data; 0 when not hit
- o_csr_hit  output  1  address is implemented here (combinational)
- o_csr_ro_write  output  1  csr_write to a user read-only shadow (0xC00-0xC9F); core raises illegal instruction
- i_instret  input  1  one-cycle pulse per retired instruction
- i_events  input  NUM_EVENTS  per-cycle event pulses
- o_overflow  output  NUM_HPM+3  one-cycle pulse when counter i wraps; bit 1 is always 0

Behaviour:
- Reset (async assert): all counters, mhpmevent, mcountinhibit, o_overflow = 0. No other state.
- Address map:
  - 0xB00/0xB80 mcycle lo/hi; 0xB02/0xB82 minstret lo/hi; 0xB03+k/0xB83+k hpm k.
  - 0x323+k mhpmevent k; 0x320 mcountinhibit.
  - 0xC00-0xC1F / 0xC80-0xC9F read-only shadows of the 0xB.. counters.
  - Hit only for implemented indices (k < NUM_HPM). 0xB01/0xB81/0xC01/0xC81 (time) are not hit.
- Reads: 0-cycle combinational from current register value. The hi half returns bits [CNT_WIDTH-1:32], zero-extended; it returns 0 when CNT_WIDTH=32.
- mcountinhibit:
  - Bits 0, 2, 3..3+NUM_HPM-1 are writable.
  - Bit 1 and bits for unimplemented counters are hardwired 0 (WARL).
  - A set bit freezes that counter; software writes to the counter still apply.
- Increment, per cycle:
  - mcycle: +1 unless inhibited.
  - minstret: +i_instret unless inhibited.
  - hpm k: +1 when sel = mhpmevent k, 1 <= sel <= NUM_EVENTS, and i_events[sel-1] = 1.
  - sel = 0 or sel > NUM_EVENTS: never counts.
- mhpmevent storage:
  - Holds clog2(NUM_EVENTS+1) bits, zero-extended on read.
  - A write value > NUM_EVENTS is stored as 0 (WARL).
- Wrap: an increment from 2^CNT_WIDTH-1 yields 0 and pulses o_overflow[i] high for exactly the next cycle. No overflow pulse on a software write.
- Software write (csr_write with a hit on 0xB.. or 0x3..):
  - lo: counter <= {old[CNT_WIDTH-1:32], wdata}.
  - hi: counter <= {wdata[CNT_WIDTH-33:0], old[31:0]}; ignored when CNT_WIDTH=32.
  - Write beats the same-cycle increment: the written value is the next value, with no +1 that cycle.
  - The other half is unaffected.
- Read-after-write: the new value is visible the following cycle.
- csr_write to 0xC.. shadow: no state change, o_csr_ro_write=1 combinationally; hit still 1.
- csr_read is advisory only; reads have no side effects.
- Reset mid-operation: all state clears immediately (async). The first increment happens on the first clk edge after rst deasserts.

Test Plan:
- Reset release, idle 10 cycles, read 0xB00 -> 10 (±1 per bench sampling convention); 0xB02 -> 0.
- Write mcycle lo=0xFFFFFFFF, hi=0 (CNT_WIDTH=64), then read 0xB80 after 1 cycle -> 1. The lo write cycle does not increment.
- NUM_HPM=4: write 0x323=2, pulse i_events[1] 5 times and i_events[0] 3 times -> 0xB03 reads 5. Write 0x324=9 (>NUM_EVENTS) -> reads 0 and never counts.
- Set mcountinhibit=0x5, run 20 cycles with i_instret=1 -> mcycle/minstret unchanged. Write 0x320=0xFFFFFFFF -> reads 0x7D (bit 1 = 0, bits >6 = 0).
- CNT_WIDTH=40: load hpm3 to 2^40-1 with event high -> wraps to 0, o_overflow[3]=1 for one cycle. Read 0xB83 -> 0.
- csr_write to 0xC00 -> o_csr_ro_write=1, mcycle continues unchanged. Read 0x33F (unimplemented) -> o_csr_hit=0, readdata=0.

Source files
------------

// File: rtl/mhpm_csr.sv
// Machine-mode performance counter CSR bank: mcycle, minstret, NUM_HPM event
// counters with selectors, mcountinhibit, and the user read-only shadows.
module mhpm_cnt #(
  parameter int W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] lo_o,
  output logic [31:0] hi_o,
  output logic        ovf_o
);
  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;
  logic [63:0]  wide_q;
  logic [W:0]   sum;

  // Zero-extended 64-bit view; truncating back to W drops hi bits above W,
  // which also makes a hi write a no-op when W is 32.
  assign wide_q = 64'(cnt_q);
  assign sum    = {1'b0, cnt_q} + (W+1)'(1);

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (wr_lo_i)      cnt_d = W'({wide_q[63:32], wdata_i});
    else if (wr_hi_i) cnt_d = W'({wdata_i, wide_q[31:0]});
    else if (inc_i) begin
      cnt_d = sum[W-1:0];
      ovf_d = sum[W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign lo_o  = wide_q[31:0];
  assign hi_o  = wide_q[63:32];
  assign ovf_o = ovf_q;
endmodule

module mhpm_csr #(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csr_read,
  input  logic                  csr_write,
  input  logic [11:0]           csr_address,
  input  logic [31:0]           csr_writedata,
  output logic [31:0]           csr_readdata,
  output logic                  o_csr_hit,
  output logic                  o_csr_ro_write,
  input  logic                  i_instret,
  input  logic [NUM_EVENTS-1:0] i_events,
  output logic [NUM_HPM+2:0]    o_overflow
);
  localparam int NCNT  = NUM_HPM + 3;
  localparam int EVW   = $clog2(NUM_EVENTS + 1);
  localparam int HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [NCNT-1:0] INH_MASK = ~NCNT'(2);

  logic [NCNT-1:0][31:0]    lo, hi;
  logic [NCNT-1:0]          ovf;
  logic [NCNT-1:0]          inh_q, inh_d;
  logic [HPM_N-1:0][EVW-1:0] sel_q, sel_d;

  logic [4:0]  idx;
  logic        hi_half, sp_cnt, sp_shadow, sp_cfg;
  logic        cnt_hit, cfg_hit;
  logic [31:0] cnt_data, cfg_data;
  logic        unused_rd;

  // Reads have no side effects, so the read strobe is not needed.
  assign unused_rd = csr_read;

  assign idx       = csr_address[4:0];
  assign hi_half   = csr_address[7];
  assign sp_cnt    = (csr_address[11:8] == 4'hB) && (csr_address[6:5] == 2'b00);
  assign sp_shadow = (csr_address[11:8] == 4'hC) && (csr_address[6:5] == 2'b00);
  assign sp_cfg    = (csr_address[11:5] == 7'h19);

  always_comb begin
    cnt_hit  = 1'b0;
    cnt_data = '0;
    cfg_hit  = 1'b0;
    cfg_data = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (i != 1 && idx == 5'(i)) begin
        cnt_hit  = 1'b1;
        cnt_data = hi_half ? hi[i] : lo[i];
      end
    end
    if (idx == 5'd0) begin
      cfg_hit  = 1'b1;
      cfg_data = 32'(inh_q);
    end
    for (int k = 0; k < NUM_HPM; k++) begin
      if (idx == 5'(k + 3)) begin
        cfg_hit  = 1'b1;
        cfg_data = 32'(sel_q[k]);
      end
    end
  end

  assign o_csr_hit      = ((sp_cnt || sp_shadow) && cnt_hit) || (sp_cfg && cfg_hit);
  assign o_csr_ro_write = csr_write && sp_shadow && cnt_hit;
  assign csr_readdata   = !o_csr_hit ? '0 : (sp_cfg ? cfg_data : cnt_data);

  // Out-of-range selectors are folded to 0 so they can never match an event.
  always_comb begin
    inh_d = inh_q;
    sel_d = sel_q;
    if (csr_write && sp_cfg) begin
      if (idx == 5'd0) inh_d = csr_writedata[NCNT-1:0] & INH_MASK;
      for (int k = 0; k < NUM_HPM; k++) begin
        if (idx == 5'(k + 3))
          sel_d[k] = (csr_writedata > 32'(NUM_EVENTS)) ? '0 : csr_writedata[EVW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inh_q <= '0;
      sel_q <= '0;
    end else begin
      inh_q <= inh_d;
      sel_q <= sel_d;
    end
  end

  for (genvar i = 0; i < NCNT; i++) begin : g_cnt
    if (i == 1) begin : g_time
      assign lo[i]  = '0;
      assign hi[i]  = '0;
      assign ovf[i] = 1'b0;
    end else begin : g_ctr
      logic inc, wr_lo, wr_hi, sel_w;
      assign sel_w = csr_write && sp_cnt && (idx == 5'(i));
      assign wr_lo = sel_w && !hi_half;
      assign wr_hi = sel_w && hi_half;
      if (i == 0) begin : g_cyc
        assign inc = !inh_q[0];
      end else if (i == 2) begin : g_ret
        assign inc = i_instret && !inh_q[2];
      end else begin : g_hpm
        logic ev;
        always_comb begin
          ev = 1'b0;
          for (int e = 0; e < NUM_EVENTS; e++)
            if (sel_q[i-3] == EVW'(e + 1) && i_events[e]) ev = 1'b1;
        end
        assign inc = ev && !inh_q[i];
      end
      mhpm_cnt #(.W(CNT_WIDTH)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (inc),
        .wr_lo_i (wr_lo),
        .wr_hi_i (wr_hi),
        .wdata_i (csr_writedata),
        .lo_o    (lo[i]),
        .hi_o    (hi[i]),
        .ovf_o   (ovf[i])
      );
    end
  end

  assign o_overflow = ovf;
endmodule

// File: tb/tb_mhpm_csr.sv
// Bench for mhpm_csr: directed stimulus, a cycle-level reference model of the
// counter bank, and literal expectations at the interesting points.
module tb_mhpm_csr;
  localparam int NH = 4;
  localparam int CW = 40;
  localparam int NE = 8;
  localparam logic [63:0] MASK = (64'd1 << CW) - 64'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_read = 1'b0;
  logic        csr_write = 1'b0;
  logic [11:0] csr_address = 12'hB00;
  logic [31:0] csr_writedata = '0;
  logic [31:0] csr_readdata;
  logic        o_csr_hit, o_csr_ro_write;
  logic        i_instret = 1'b0;
  logic [NE-1:0] i_events = '0;
  logic [NH+2:0] o_overflow;

  int n_chk = 0;
  int n_fail = 0;

  mhpm_csr #(.NUM_HPM(NH), .CNT_WIDTH(CW), .NUM_EVENTS(NE)) dut (
    .clk(clk), .rst(rst), .csr_read(csr_read), .csr_write(csr_write),
    .csr_address(csr_address), .csr_writedata(csr_writedata),
    .csr_readdata(csr_readdata), .o_csr_hit(o_csr_hit),
    .o_csr_ro_write(o_csr_ro_write), .i_instret(i_instret),
    .i_events(i_events), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: counters as plain 64-bit numbers masked to CW bits.
  logic [63:0] m_cnt [7] = '{default: 64'd0};
  logic [6:0]  m_inh = '0;
  logic [6:0]  m_ovf = '0;
  int          m_sel [4] = '{default: 0};

  function automatic bit counts(input int i);
    if (m_inh[i]) return 1'b0;
    if (i == 0) return 1'b1;
    if (i == 2) return i_instret;
    if (m_sel[i-3] >= 1 && m_sel[i-3] <= NE) return i_events[m_sel[i-3]-1];
    return 1'b0;
  endfunction

  function automatic bit wr_at(input logic [11:0] a);
    return csr_write && csr_address == a;
  endfunction

  function automatic logic [63:0] next_cnt(input int i);
    logic [63:0] v;
    v = m_cnt[i];
    if (wr_at(12'hB00 + 12'(i)))      v = {v[63:32], csr_writedata};
    else if (wr_at(12'hB80 + 12'(i))) v = {csr_writedata, v[31:0]};
    else if (counts(i))               v = v + 64'd1;
    return v & MASK;
  endfunction

  function automatic bit next_ovf(input int i);
    return !wr_at(12'hB00 + 12'(i)) && !wr_at(12'hB80 + 12'(i)) &&
           counts(i) && m_cnt[i] == MASK;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 7; i++) m_cnt[i] <= 64'd0;
      for (int k = 0; k < 4; k++) m_sel[k] <= 0;
      m_inh <= '0;
      m_ovf <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (i != 1) begin
          m_cnt[i] <= next_cnt(i);
          m_ovf[i] <= next_ovf(i);
        end
      end
      if (wr_at(12'h320)) m_inh <= csr_writedata[6:0] & 7'h7D;
      for (int k = 0; k < 4; k++)
        if (wr_at(12'h323 + 12'(k)))
          m_sel[k] <= (csr_writedata > 32'(NE)) ? 0 : int'(csr_writedata);
    end
  end

  task automatic exp_rd(input logic [11:0] a, output logic hit,
                        output logic [31:0] d, output logic ro);
    int n;
    bit lo_reg, hi_reg;
    hit = 1'b0; d = '0; ro = 1'b0;
    n = int'(a[4:0]);
    lo_reg = (a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hC00 && a <= 12'hC1F);
    hi_reg = (a >= 12'hB80 && a <= 12'hB9F) || (a >= 12'hC80 && a <= 12'hC9F);
    if ((lo_reg || hi_reg) && n < 7 && n != 1) begin
      hit = 1'b1;
      d   = hi_reg ? m_cnt[n][63:32] : m_cnt[n][31:0];
      ro  = csr_write && a >= 12'hC00;
    end else if (a == 12'h320) begin
      hit = 1'b1;
      d   = 32'(m_inh);
    end else if (a >= 12'h323 && a <= 12'h326) begin
      hit = 1'b1;
      d   = 32'(m_sel[a - 12'h323]);
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle: all outputs against the model.
  always @(negedge clk) begin
    logic eh, ero;
    logic [31:0] ed;
    exp_rd(csr_address, eh, ed, ero);
    check("model_hit", 32'(o_csr_hit), 32'(eh));
    check("model_rdata", csr_readdata, ed);
    check("model_ro_write", 32'(o_csr_ro_write), 32'(ero));
    check("model_overflow", 32'(o_overflow), 32'(m_ovf));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_write = 1'b1;
    csr_address = a;
    csr_writedata = d;
    tick();
    csr_write = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
    csr_address = a;
    @(negedge clk);
    check(nm, csr_readdata, exp);
  endtask

  initial begin
    // reset state
    rd_chk("rst_mcycle", 12'hB00, 32'h0);
    check("rst_overflow", 32'(o_overflow), 32'h0);
    tick(); tick();
    rst = 1'b0;
    repeat (10) tick();
    rd_chk("idle_mcycle", 12'hB00, 32'd10);
    rd_chk("idle_minstret", 12'hB02, 32'd0);

    // lo/hi writes suppress the increment; carry into hi
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0);
    rd_chk("wr_no_inc", 12'hB00, 32'hFFFF_FFFF);
    rd_chk("carry_hi", 12'hB80, 32'd1);
    rd_chk("carry_lo", 12'hB00, 32'd1);

    // event selection
    wr(12'h323, 32'd2);
    for (int p = 0; p < 5; p++) begin i_events = 8'h02; tick(); i_events = '0; tick(); end
    for (int p = 0; p < 3; p++) begin i_events = 8'h01; tick(); i_events = '0; tick(); end
    rd_chk("hpm3_five", 12'hB03, 32'd5);
    wr(12'h324, 32'd9);
    rd_chk("sel_warl", 12'h324, 32'd0);
    wr(12'h325, 32'd8);
    rd_chk("sel_max", 12'h325, 32'd8);
    i_events = 8'hFF;
    repeat (4) tick();
    i_events = '0;
    rd_chk("hpm4_never", 12'hB04, 32'd0);
    rd_chk("hpm3_nine", 12'hB03, 32'd9);
    rd_chk("hpm5_four", 12'hB05, 32'd4);

    // inhibit freezes counters, software writes still land
    wr(12'h320, 32'h5);
    wr(12'hB00, 32'h100);
    wr(12'hB80, 32'h0);
    wr(12'hB02, 32'h200);
    wr(12'hB82, 32'h0);
    i_instret = 1'b1;
    repeat (20) tick();
    rd_chk("inh_mcycle", 12'hB00, 32'h100);
    rd_chk("inh_mcycle_hi", 12'hB80, 32'h0);
    rd_chk("inh_minstret", 12'hB02, 32'h200);
    wr(12'h320, 32'hFFFF_FFFF);
    rd_chk("inh_warl", 12'h320, 32'h7D);
    wr(12'h320, 32'h0);
    for (int p = 0; p < 6; p++) begin i_instret = p[0]; tick(); end
    i_instret = 1'b0;

    // wrap at 2^40-1
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'hFFFF_FFFF);
    rd_chk("hi_trunc", 12'hB83, 32'hFF);
    rd_chk("hpm3_full", 12'hB03, 32'hFFFF_FFFF);
    i_events = 8'h02;
    tick();
    i_events = '0;
    @(negedge clk);
    check("ovf_pulse", 32'(o_overflow), 32'h08);
    tick();
    @(negedge clk);
    check("ovf_clear", 32'(o_overflow), 32'h0);
    rd_chk("wrap_hi", 12'hB83, 32'h0);
    rd_chk("wrap_lo", 12'hB03, 32'h0);

    // read-only shadow and unimplemented addresses
    csr_write = 1'b1; csr_address = 12'hC00; csr_writedata = 32'h1234;
    @(negedge clk);
    check("ro_write", 32'(o_csr_ro_write), 32'h1);
    check("ro_hit", 32'(o_csr_hit), 32'h1);
    tick();
    csr_write = 1'b0;
    rd_chk("unimpl_rd", 12'h33F, 32'h0);
    check("unimpl_hit", 32'(o_csr_hit), 32'h0);
    rd_chk("time_rd", 12'hB01, 32'h0);
    check("time_hit", 32'(o_csr_hit), 32'h0);
    rd_chk("hpm7_rd", 12'hB07, 32'h0);
    check("hpm7_hit", 32'(o_csr_hit), 32'h0);

    // asynchronous reset mid-operation
    csr_address = 12'hB00;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("async_rst", csr_readdata, 32'h0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    rd_chk("post_rst_mcycle", 12'hB00, 32'd3);
    rd_chk("post_rst_sel", 12'h323, 32'd0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
